// File: rtl/rv32i_mc_ctrl.sv
// rv32i_mc_ctrl: multi-cycle control FSM for the RV32I core.
// The state register updates on posedge clka. The datapath captures on ~clka.
module rv32i_mc_ctrl #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clka,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       ZF,
    input  logic       LT,
    input  logic       LTU,
    output logic       PC_write,
    output logic       IR_write,
    output logic       PC0_Write,
    output logic [1:0] PC_S,
    output logic       Reg_Write,
    output logic       Mem_Write,
    output logic [3:0] ALU_OP,
    output logic       B_s,
    output logic       A_s,
    output logic [1:0] W_s,
    output logic       illegal,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_FETCH = 4'd1, S_DEC = 4'd2, S_REXE = 4'd3, S_IEXE = 4'd4,
        S_WB = 4'd5, S_LUI = 4'd6, S_ADDR = 4'd7, S_LD = 4'd8, S_LDWB = 4'd9,
        S_ST = 4'd10, S_BR = 4'd11, S_JAL = 4'd12, S_JALR = 4'd13
    } state_e;

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic [3:0] alu_op_q;
    logic       b_s_q;
    logic       br_taken;

    // Low funct3 bit inverts the sense. 010 and 011 are never taken.
    assign br_taken = funct3[2] ? ((funct3[1] ? LTU : LT) ^ funct3[0])
                                : (!funct3[1] && (ZF ^ funct3[0]));
    assign state    = state_q;
    assign illegal  = illegal_q;

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= state_e'(RESET_STATE);
            illegal_q <= 1'b0;
            alu_op_q  <= 4'd0;
            b_s_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            alu_op_q  <= ALU_OP;
            b_s_q     <= B_s;
        end
    end

    always_comb begin
        state_d   = S_FETCH;
        illegal_d = illegal_q;
        PC_write  = 1'b0;
        IR_write  = 1'b0;
        PC0_Write = 1'b0;
        PC_S      = 2'd0;
        Reg_Write = 1'b0;
        Mem_Write = 1'b0;
        ALU_OP    = 4'd0;
        B_s       = 1'b0;
        A_s       = 1'b0;
        W_s       = 2'd0;
        case (state_q)
            S_FETCH: begin
                IR_write  = 1'b1;
                PC_write  = 1'b1;
                PC0_Write = 1'b1;
                state_d   = S_DEC;
            end
            S_DEC: begin
                case (opcode)
                    7'b0110011:             state_d = S_REXE;
                    7'b0010011:             state_d = S_IEXE;
                    7'b0000011, 7'b0100011: state_d = S_ADDR;
                    7'b0110111:             state_d = S_LUI;
                    7'b1100011:             state_d = S_BR;
                    7'b1101111:             state_d = S_JAL;
                    7'b1100111:             state_d = S_JALR;
                    default:                illegal_d = 1'b1;
                endcase
            end
            S_REXE: begin
                ALU_OP  = {funct7_5, funct3};
                state_d = S_WB;
            end
            S_IEXE: begin
                B_s     = 1'b1;
                ALU_OP  = {funct3 == 3'b101 && funct7_5, funct3};
                state_d = S_WB;
            end
            S_WB: begin
                Reg_Write = 1'b1;
                ALU_OP    = alu_op_q;
                B_s       = b_s_q;
            end
            S_LUI: begin
                Reg_Write = 1'b1;
                W_s       = 2'd2;
            end
            S_ADDR: begin
                B_s     = 1'b1;
                state_d = opcode[5] ? S_ST : S_LD;
            end
            S_LD: begin
                ALU_OP  = alu_op_q;
                B_s     = b_s_q;
                state_d = S_LDWB;
            end
            S_LDWB: begin
                Reg_Write = 1'b1;
                W_s       = 2'd1;
            end
            S_ST: begin
                Mem_Write = 1'b1;
                ALU_OP    = alu_op_q;
                B_s       = b_s_q;
            end
            S_BR: begin
                ALU_OP    = 4'b1000;
                PC_write  = br_taken;
                PC_S      = {1'b0, br_taken};
                illegal_d = illegal_q | (funct3[2:1] == 2'b01);
            end
            S_JAL: begin
                PC_write  = 1'b1;
                PC_S      = 2'd1;
                Reg_Write = 1'b1;
                W_s       = 2'd3;
            end
            S_JALR: begin
                B_s       = 1'b1;
                PC_write  = 1'b1;
                PC_S      = 2'd2;
                Reg_Write = 1'b1;
                W_s       = 2'd3;
            end
            default: ;
        endcase
    end
endmodule
